// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter with packet locking that shares one UART TX
//            line (8N1, LSB first) between N byte-stream requesters.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 locked
);

  localparam int c_IDW = $clog2(N);
  localparam int c_BW  = $clog2(CLKS_PER_BIT);
  localparam int c_TW  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_BW-1:0]   r_bit_cnt;
  logic [2:0]        r_dat_cnt;
  logic [7:0]        r_shift;
  logic [c_IDW-1:0]  r_ptr;
  logic [c_IDW-1:0]  r_grant;
  logic [c_TW-1:0]   r_timer;
  logic              r_tx;
  logic              r_busy;
  logic              r_locked;

  logic              w_rr_found;
  logic [c_IDW-1:0]  w_rr_sel;
  logic [N-1:0]      w_ready;
  logic              w_hs;
  logic [c_IDW-1:0]  w_hs_id;
  logic [7:0]        w_hs_byte;
  logic              w_bit_end;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    int               idx;
    logic [c_IDW-1:0] cand;
    idx        = 0;
    cand       = '0;
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    for (int k = 1; k <= N; k++) begin
      idx  = (int'(r_ptr) + k) % N;
      cand = c_IDW'(idx);
      if (!w_rr_found && req_valid[cand]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE)) begin
      if (r_locked) begin
        w_ready[r_grant] = req_valid[r_grant];
      end else if (w_rr_found) begin
        w_ready[w_rr_sel] = 1'b1;
      end
    end
  end

  assign w_hs    = |(w_ready & req_valid);
  assign w_hs_id = r_locked ? r_grant : w_rr_sel;

  always_comb begin
    w_hs_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (w_hs_id == c_IDW'(i)) begin
        w_hs_byte = req_data[8*i +: 8];
      end
    end
  end

  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hs)                                w_state_nxt = S_START;
      S_START: if (w_bit_end)                           w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && (r_dat_cnt == 3'd7))    w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end)                           w_state_nxt = S_IDLE;
      default:                                          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_dat_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= c_IDW'(N - 1);
      r_grant   <= '0;
      r_timer   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          r_dat_cnt <= '0;
          if (w_hs) begin
            r_shift  <= w_hs_byte;
            r_grant  <= w_hs_id;
            r_ptr    <= w_hs_id;
            r_locked <= ~req_last[w_hs_id];
            r_timer  <= '0;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
          end else if ((LOCK_TIMEOUT > 0) && r_locked && !req_valid[r_grant]) begin
            // A stalled lock holder loses the line after LOCK_TIMEOUT idle clocks.
            if (r_timer == c_TMO_LAST) begin
              r_locked <= 1'b0;
              r_timer  <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_dat_cnt == 3'd7) begin
              r_dat_cnt <= '0;
              r_tx      <= 1'b1;
            end else begin
              r_dat_cnt <= r_dat_cnt + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_dat_cnt <= '0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign locked    = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [8*N-1:0]   req_data;
  logic             tx, busy, locked;
  logic [1:0]       grant_id;

  logic [1:0]       b_valid, b_last, b_ready;
  logic [15:0]      b_data;
  logic             b_tx, b_busy, b_locked;
  logic [0:0]       b_gid;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int last_hs = 0;

  logic [7:0] q_data [N][4];
  logic       q_last [N][4];
  int         q_len  [N];
  int         q_pos  [N];

  uart_tx_arbiter #(.N(N), .CLKS_PER_BIT(16), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx(tx), .busy(busy),
    .grant_id(grant_id), .locked(locked)
  );

  uart_tx_arbiter #(.N(2), .CLKS_PER_BIT(4), .LOCK_TIMEOUT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data),
    .req_last(b_last), .req_ready(b_ready), .tx(b_tx), .busy(b_busy),
    .grant_id(b_gid), .locked(b_locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (q_pos[i] < q_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = q_data[i][q_pos[i]];
        req_last[i]        = q_last[i][q_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input int len,
                      input logic last_mid, input logic last_end);
    q_data[i][0] = d0; q_data[i][1] = d1; q_data[i][2] = d2; q_data[i][3] = 8'h00;
    for (int j = 0; j < 4; j++) q_last[i][j] = (j == len - 1) ? last_end : last_mid;
    q_len[i] = len;
    q_pos[i] = 0;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      q_len[i] = 0;
      q_pos[i] = 0;
    end
    present();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_q();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns with id of the requester that will handshake
  // on the next rising edge, or -1 if none within the bound.
  task automatic wait_hs(output int id);
    bit found;
    found = 1'b0;
    id    = -1;
    for (int w = 0; w < 400 && !found; w++) begin
      #1;
      if (|(req_ready & req_valid)) begin
        found = 1'b1;
        for (int i = N - 1; i >= 0; i--) if (req_ready[i] && req_valid[i]) id = i;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic serve(input int exp_id, input logic [7:0] exp_byte,
                       input logic exp_lock, input int exp_gap);
    int           id;
    int           bc;
    logic [9:0]   f;
    logic [9:0]   exp_f;
    logic [N-1:0] exp_rdy;
    wait_hs(id);
    tests++;
    if (id != exp_id) begin
      fails++;
      $display("FAIL grant: got requester %0d, expected %0d (cycle %0d)", id, exp_id, cyc);
      if (id < 0) return;
    end
    exp_rdy = '0;
    exp_rdy[exp_id] = 1'b1;
    tests++;
    if (req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL ready: got %b, expected %b", req_ready, exp_rdy);
    end
    if (exp_gap > 0) begin
      tests++;
      if (cyc - last_hs != exp_gap) begin
        fails++;
        $display("FAIL spacing: got %0d cycles, expected %0d", cyc - last_hs, exp_gap);
      end
    end
    last_hs = cyc;
    @(posedge clk);
    #1;
    q_pos[id]++;
    present();
    bc = 0;
    f  = '0;
    for (int c = 0; c <= 160; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (grant_id !== 2'(exp_id) || locked !== exp_lock) begin
          fails++;
          $display("FAIL grant_lock: got grant_id=%0d locked=%b, expected %0d/%b",
                   grant_id, locked, exp_id, exp_lock);
        end
      end
      if (busy === 1'b1) bc++;
      if ((c % 16 == 8) && (c < 160)) f[c/16] = tx;
    end
    exp_f = {1'b1, exp_byte, 1'b0};
    tests++;
    if (f !== exp_f) begin
      fails++;
      $display("FAIL frame: got %b, expected %b", f, exp_f);
    end
    tests++;
    if (bc != 160) begin
      fails++;
      $display("FAIL busy_len: got %0d cycles, expected 160", bc);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_last  = '1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (req_ready !== '0 || tx !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL reset: ready=%b tx=%b busy=%b grant=%0d locked=%b, expected 0000/1/0/0/0",
               req_ready, tx, busy, grant_id, locked);
    end
    clear_q();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    load(0, 8'hA5, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    present();
    serve(0, 8'hA5, 1'b0, -1);
  endtask

  task automatic test_contention();
    load(0, 8'h31, 8'h32, 8'h00, 2, 1'b1, 1'b1);
    load(2, 8'h51, 8'h52, 8'h00, 2, 1'b1, 1'b1);
    present();
    serve(0, 8'h31, 1'b0, -1);
    serve(2, 8'h51, 1'b0, 161);
    serve(0, 8'h32, 1'b0, 161);
    serve(2, 8'h52, 1'b0, 161);
  endtask

  task automatic test_packet_lock();
    load(0, 8'h01, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    present();
    serve(0, 8'h01, 1'b0, -1);
    load(1, 8'h10, 8'h11, 8'h12, 3, 1'b0, 1'b1);
    load(0, 8'h77, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    present();
    serve(1, 8'h10, 1'b1, 161);
    serve(1, 8'h11, 1'b1, 161);
    serve(1, 8'h12, 1'b0, 161);
    serve(0, 8'h77, 1'b0, 161);
  endtask

  task automatic test_lock_timeout();
    int held;
    load(3, 8'h5A, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    present();
    serve(3, 8'h5A, 1'b1, 161);
    load(1, 8'h99, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    present();
    held = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (locked === 1'b1 && req_ready === '0) held++;
      @(negedge clk);
    end
    tests++;
    if (held != 8) begin
      fails++;
      $display("FAIL lock_hold: got %0d stalled locked cycles, expected 8", held);
    end
    serve(1, 8'h99, 1'b0, 169);
  endtask

  task automatic test_reset_midframe();
    int id;
    load(1, 8'h3C, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    present();
    wait_hs(id);
    tests++;
    if (id != 1) begin
      fails++;
      $display("FAIL mid_grant: got requester %0d, expected 1", id);
    end
    @(posedge clk);
    #1;
    q_pos[1]++;
    present();
    for (int c = 0; c <= 84; c++) @(negedge clk);
    #1;
    tests++;
    if (locked !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_prereset: got locked=%b busy=%b, expected 1/1", locked, busy);
    end
    load(0, 8'h81, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    load(1, 8'h82, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    present();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 || grant_id !== 2'd0 || req_ready !== '0) begin
      fails++;
      $display("FAIL mid_reset: tx=%b busy=%b locked=%b grant=%0d ready=%b, expected 1/0/0/0/0000",
               tx, busy, locked, grant_id, req_ready);
    end
    rst_n = 1'b1;
    serve(0, 8'h81, 1'b0, -1);
    serve(1, 8'h82, 1'b0, 161);
  endtask

  task automatic test_idle();
    int bad;
    clear_q();
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || req_ready !== '0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle: got %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_n2_wrap();
    int w;
    @(negedge clk);
    b_data  = {8'hB1, 8'hB0};
    b_last  = 2'b11;
    b_valid = 2'b10;
    #1;
    tests++;
    if (b_ready !== 2'b10) begin
      fails++;
      $display("FAIL n2_first: got ready %b, expected 10", b_ready);
    end
    @(posedge clk);
    #1;
    b_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (b_gid !== 1'b1 || b_tx !== 1'b0) begin
      fails++;
      $display("FAIL n2_grant1: got grant=%0d tx=%b, expected 1/0", b_gid, b_tx);
    end
    w = 0;
    while (b_busy === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (b_busy !== 1'b0) begin
      fails++;
      $display("FAIL n2_frame_end: got busy=%b after %0d cycles, expected 0", b_busy, w);
    end
    b_valid = 2'b11;
    #1;
    tests++;
    if (b_ready !== 2'b01) begin
      fails++;
      $display("FAIL n2_wrap: got ready %b, expected 01", b_ready);
    end
    @(posedge clk);
    #1;
    b_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (b_gid !== 1'b0 || b_tx !== 1'b0) begin
      fails++;
      $display("FAIL n2_grant0: got grant=%0d tx=%b, expected 0/0", b_gid, b_tx);
    end
  endtask

  initial begin
    b_valid = 2'b00;
    b_last  = 2'b00;
    b_data  = 16'h0000;
    for (int i = 0; i < N; i++) begin
      q_len[i] = 0;
      q_pos[i] = 0;
    end
    test_reset();
    test_single_byte();
    do_reset();
    test_contention();
    test_packet_lock();
    test_lock_timeout();
    test_reset_midframe();
    test_idle();
    do_reset();
    test_n2_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between N byte-stream requesters.
- Round-robin arbitration per byte, with optional packet locking: a requester keeps the line until it sends a byte flagged last.
- Contains its own serializer. Frame format and bit timing match the team's UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, CLKS_PER_BIT clocks per bit.
- Sits between protocol engines (command responders, debug printers) and the board TX pin.

Parameters:
- N, 4, number of requesters (2..8).
- CLKS_PER_BIT, 16, clocks per serial bit (≥2).
- LOCK_TIMEOUT, 1024, idle clocks a locked requester may stall before its lock is dropped; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  N  requester i has a byte pending.
- req_data  input  8*N  byte of requester i in bits [8i+7:8i].
- req_last  input  N  byte of requester i ends its packet.
- req_ready  output  N  one-hot, combinational; transfer when valid&ready on same edge.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  registered; high while a frame is on tx (START..STOP).
- grant_id  output  clog2(N)  registered; index of the last accepted requester.
- locked  output  1  registered; packet lock held by grant_id.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE, tx=1, busy=0, grant_id=0, locked=0, lock timer=0.
  - RR pointer = N-1, so requester 0 has first priority.
  - req_ready=0 while rst_n is low.
  - Reset mid-frame aborts the frame: tx is 1 from the next cycle and the partial byte is dropped.
- States: IDLE, START, DATA, STOP.
  - A bit counter (0..CLKS_PER_BIT-1) and a data-bit counter (0..7) are cleared on every state entry.
- IDLE, req_ready:
  - Not locked: req_ready[i]=1 for the first i with req_valid[i]=1, searching (ptr+1, ptr+2, ... mod N).
  - Locked: req_ready[grant_id]=req_valid[grant_id]; all others 0.
  - In any state other than IDLE, req_ready is all 0.
- IDLE, handshake at edge T:
  - Latch data into a shift register; grant_id<=i; ptr<=i; locked<=~req_last[i].
  - State goes to START; tx=0 and busy=1 from T+1.
- START: CLKS_PER_BIT cycles at tx=0, then DATA.
- DATA: each bit holds CLKS_PER_BIT cycles, LSB first; after bit 7, go to STOP.
- STOP: CLKS_PER_BIT cycles at tx=1; busy stays 1; then IDLE with busy=0.
- Frame length: 10*CLKS_PER_BIT cycles. The next handshake is possible on the first IDLE cycle, giving a minimum start-to-start spacing of 10*CLKS_PER_BIT+1 cycles.
- Lock timeout (LOCK_TIMEOUT>0):
  - In IDLE with locked=1 and req_valid[grant_id]=0, the timer increments; any handshake clears it.
  - When the timer reaches LOCK_TIMEOUT: locked<=0, timer<=0, and normal RR resumes next cycle.
- Lock holder sends last=1 → locked<=0 at the handshake; the pointer equals the holder, so the next byte goes to the following requester.
- Requesters must hold valid/data/last stable until ready. Dropping valid before ready is permitted; nothing is transferred.
- No valid in IDLE: stay in IDLE; tx=1.

Test Plan:
- Single byte: req0 sends 0xA5, last=1, CLKS_PER_BIT=16 → tx bits 0,1,0,1,0,0,1,0,1,1 at 16 cycles each (start, data LSB first, stop); busy high 160 cycles; locked=0.
- Contention: req0 and req2 both valid with last=1, each with 2 bytes → grant order 0,2,0,2; start-to-start spacing exactly 161 cycles.
- Packet lock: req1 sends 0x10, 0x11, 0x12 (last on 0x12) while req0 is continuously valid → tx carries 0x10, 0x11, 0x12, then req0's byte; locked=1 after the first two bytes; req_ready[0]=0 throughout the packet.
- Lock timeout, LOCK_TIMEOUT=8: req3 sends one byte with last=0, then drops valid; req1 valid → locked clears on the timer's 8th IDLE cycle; req1 handshakes the following cycle.
- Reset mid-frame: rst_n low during DATA bit 4 → next cycle tx=1, busy=0, locked=0, grant_id=0; after release, requester 0 wins against a simultaneous requester 1.
- Idle/boundary: no requests for 500 cycles → tx=1, req_ready=0; N=2 wrap: ptr=1 with both valid → requester 0 granted.
